// File: rtl/alu_sliced_seq_if.sv
// Issue/writeback handshake bundle for the slice-serial ALU.
// The master side issues operands and accepts results; the slave side is the ALU.
interface alu_sliced_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       command;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, command, out_ready,
    input  in_ready, out_valid, result, carryout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, command, out_ready,
    output in_ready, out_valid, result, carryout, overflow, zero
  );
endinterface

// File: rtl/alu_sliced_seq.sv
// Multi-cycle ALU that pushes one SLICE-bit chunk per cycle through a ripple-carry
// datapath, LSB chunk first, with valid/ready handshakes on issue and writeback.
module alu_sliced_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input logic            clk,
  input logic            rst_n,
  alu_sliced_seq_if.slave bus
);
  localparam int unsigned N    = WIDTH / SLICE;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  localparam logic [2:0] CmdAdd  = 3'd0;
  localparam logic [2:0] CmdSub  = 3'd1;
  localparam logic [2:0] CmdXor  = 3'd2;
  localparam logic [2:0] CmdSlt  = 3'd3;
  localparam logic [2:0] CmdAnd  = 3'd4;
  localparam logic [2:0] CmdNand = 3'd5;
  localparam logic [2:0] CmdNor  = 3'd6;
  localparam logic [2:0] CmdOr   = 3'd7;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       cmd_q, cmd_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carryout_q, carryout_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic [31:0]      offs;
  logic             sub_op;
  logic             arith_op;
  logic [SLICE-1:0] a_chunk, b_chunk, bx, chunk_res;
  logic [SLICE:0]   sum_full;
  logic             cin_msb, cout;

  // Chunk datapath: one SLICE-bit ripple adder plus bitwise logic.
  always_comb begin
    offs     = 32'(cnt_q) * SLICE;
    sub_op   = (cmd_q == CmdSub) || (cmd_q == CmdSlt);
    arith_op = (cmd_q == CmdAdd) || (cmd_q == CmdSub);
    a_chunk  = a_q[offs +: SLICE];
    b_chunk  = b_q[offs +: SLICE];
    bx       = b_chunk ^ {SLICE{sub_op}};
    sum_full = {1'b0, a_chunk} + {1'b0, bx} + {{SLICE{1'b0}}, carry_q};
    // Carry into the chunk MSB recovered from the sum bit and its two addends.
    cin_msb  = sum_full[SLICE-1] ^ a_chunk[SLICE-1] ^ bx[SLICE-1];
    cout     = sum_full[SLICE];
    unique case (cmd_q)
      CmdAdd, CmdSub, CmdSlt: chunk_res = sum_full[SLICE-1:0];
      CmdXor:                 chunk_res = a_chunk ^ b_chunk;
      CmdAnd:                 chunk_res = a_chunk & b_chunk;
      CmdNand:                chunk_res = ~(a_chunk & b_chunk);
      CmdNor:                 chunk_res = ~(a_chunk | b_chunk);
      CmdOr:                  chunk_res = a_chunk | b_chunk;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    cmd_d      = cmd_q;
    carry_d    = carry_q;
    res_d      = res_q;
    carryout_d = carryout_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          cmd_d   = bus.command;
          carry_d = (bus.command == CmdSub) || (bus.command == CmdSlt);
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        res_d[offs +: SLICE] = chunk_res;
        carry_d              = cout;
        if (cnt_q == LastCnt) begin
          if (cmd_q == CmdSlt) begin
            res_d = {{(WIDTH-1){1'b0}}, sum_full[SLICE-1] ^ cin_msb ^ cout};
          end
          carryout_d = arith_op & cout;
          overflow_d = arith_op & (cin_msb ^ cout);
          zero_d     = ~|res_d;
          state_d    = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cmd_q      <= '0;
      carry_q    <= 1'b0;
      res_q      <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cmd_q      <= cmd_d;
      carry_q    <= carry_d;
      res_q      <= res_d;
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = res_q;
  assign bus.carryout  = carryout_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_sliced_seq.sv
// Directed bench for alu_sliced_seq at SLICE = 8, 32 and 1 (WIDTH = 32), with an
// expected-result queue filled on issue and drained on each writeback.
module tb_alu_sliced_seq;
  localparam logic [2:0] CmdAdd  = 3'd0;
  localparam logic [2:0] CmdSub  = 3'd1;
  localparam logic [2:0] CmdXor  = 3'd2;
  localparam logic [2:0] CmdSlt  = 3'd3;
  localparam logic [2:0] CmdAnd  = 3'd4;
  localparam logic [2:0] CmdNand = 3'd5;
  localparam logic [2:0] CmdNor  = 3'd6;
  localparam logic [2:0] CmdOr   = 3'd7;

  typedef struct packed {
    logic [31:0] result;
    logic        c;
    logic        v;
    logic        z;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  res_t sb[$];

  always #5 clk = ~clk;

  alu_sliced_seq_if #(.WIDTH(32)) bus8 ();
  alu_sliced_seq_if #(.WIDTH(32)) bus32 ();
  alu_sliced_seq_if #(.WIDTH(32)) bus1 ();

  alu_sliced_seq #(.WIDTH(32), .SLICE(8))  u_s8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  alu_sliced_seq #(.WIDTH(32), .SLICE(32)) u_s32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  alu_sliced_seq #(.WIDTH(32), .SLICE(1))  u_s1  (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
    res_t        r;
    logic [32:0] s;
    r = '0;
    unique case (cmd)
      CmdAdd: begin
        s        = {1'b0, a} + {1'b0, b};
        r.result = s[31:0];
        r.c      = s[32];
        r.v      = (a[31] == b[31]) && (s[31] != a[31]);
      end
      CmdSub: begin
        s        = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r.result = s[31:0];
        r.c      = s[32];
        r.v      = (a[31] != b[31]) && (s[31] != a[31]);
      end
      CmdSlt:  r.result = {31'd0, $signed(a) < $signed(b)};
      CmdXor:  r.result = a ^ b;
      CmdAnd:  r.result = a & b;
      CmdNand: r.result = ~(a & b);
      CmdNor:  r.result = ~(a | b);
      CmdOr:   r.result = a | b;
    endcase
    r.z = (r.result == 32'd0);
    return r;
  endfunction

  task automatic set_in(input int idx, input logic v, input logic [2:0] cmd,
                        input logic [31:0] a, input logic [31:0] b);
    case (idx)
      0: begin bus8.in_valid = v;  bus8.command = cmd;  bus8.a = a;  bus8.b = b;  end
      1: begin bus32.in_valid = v; bus32.command = cmd; bus32.a = a; bus32.b = b; end
      default: begin bus1.in_valid = v; bus1.command = cmd; bus1.a = a; bus1.b = b; end
    endcase
  endtask

  task automatic set_ordy(input int idx, input logic v);
    case (idx)
      0: bus8.out_ready = v;
      1: bus32.out_ready = v;
      default: bus1.out_ready = v;
    endcase
  endtask

  function automatic res_t get_out(input int idx);
    case (idx)
      0: return {bus8.result, bus8.carryout, bus8.overflow, bus8.zero};
      1: return {bus32.result, bus32.carryout, bus32.overflow, bus32.zero};
      default: return {bus1.result, bus1.carryout, bus1.overflow, bus1.zero};
    endcase
  endfunction

  function automatic logic get_ovalid(input int idx);
    case (idx)
      0: return bus8.out_valid;
      1: return bus32.out_valid;
      default: return bus1.out_valid;
    endcase
  endfunction

  function automatic logic get_iready(input int idx);
    case (idx)
      0: return bus8.in_ready;
      1: return bus32.in_ready;
      default: return bus1.in_ready;
    endcase
  endfunction

  // Issue one op, wait (bounded) for the result, then check it and drain it.
  task automatic issue_and_wait(input int idx, input logic [2:0] cmd, input logic [31:0] a,
                                input logic [31:0] b, input int lat, input string tag,
                                output res_t got);
    int   n;
    res_t e;
    @(negedge clk);
    check({tag, ":in_ready"}, 64'(get_iready(idx)), 64'd1);
    set_in(idx, 1'b1, cmd, a, b);
    sb.push_back(model(cmd, a, b));
    @(posedge clk);
    #1;
    set_in(idx, 1'b0, 3'd0, 32'd0, 32'd0);
    n = 0;
    while (!get_ovalid(idx) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, ":latency"}, 64'(n), 64'(lat));
    e   = sb.pop_front();
    got = get_out(idx);
    check({tag, ":result"}, 64'(got.result), 64'(e.result));
    check({tag, ":flags_cvz"}, 64'({got.c, got.v, got.z}), 64'({e.c, e.v, e.z}));
  endtask

  task automatic retire(input int idx, input string tag);
    set_ordy(idx, 1'b1);
    @(posedge clk);
    #1;
    set_ordy(idx, 1'b0);
    check({tag, ":idle_ov_ir"}, 64'({get_ovalid(idx), get_iready(idx)}), 64'(2'b01));
  endtask

  task automatic do_op(input int idx, input logic [2:0] cmd, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input string tag);
    res_t got;
    issue_and_wait(idx, cmd, a, b, lat, tag, got);
    retire(idx, tag);
  endtask

  task automatic arith_suite(input int idx, input int lat);
    do_op(idx, CmdAdd, 32'h7FFF_FFFF, 32'h0000_0001, lat, $sformatf("i%0d_add_ovf", idx));
    do_op(idx, CmdSlt, 32'hFFFF_FFFF, 32'h0000_0001, lat, $sformatf("i%0d_slt_m1_1", idx));
    do_op(idx, CmdSlt, 32'h8000_0000, 32'h7FFF_FFFF, lat, $sformatf("i%0d_slt_min_max", idx));
    do_op(idx, CmdSlt, 32'h7FFF_FFFF, 32'h8000_0000, lat, $sformatf("i%0d_slt_max_min", idx));
    do_op(idx, CmdSlt, 32'h0000_0005, 32'h0000_0005, lat, $sformatf("i%0d_slt_eq", idx));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res_t held;
    res_t now;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(i, 1'b0, 3'd0, 32'd0, 32'd0);
      set_ordy(i, 1'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("i%0d_reset_ov_ir", i), 64'({get_ovalid(i), get_iready(i)}), 64'(2'b01));
      check($sformatf("i%0d_reset_outs", i), 64'(get_out(i)), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Arithmetic and SLT corner cases, SLICE = 8.
    arith_suite(0, 4);
    do_op(0, CmdSub, 32'h0000_0005, 32'h0000_0005, 4, "sub_eq");
    do_op(0, CmdAdd, 32'hFFFF_FFFF, 32'h0000_0001, 4, "add_wrap");
    do_op(0, CmdSub, 32'h8000_0000, 32'h0000_0001, 4, "sub_ovf");

    // Logic ops.
    do_op(0, CmdXor,  32'hA5A5_A5A5, 32'h0F0F_0F0F, 4, "xor");
    do_op(0, CmdAnd,  32'hA5A5_A5A5, 32'h0F0F_0F0F, 4, "and");
    do_op(0, CmdNand, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 4, "nand");
    do_op(0, CmdNor,  32'hA5A5_A5A5, 32'h0F0F_0F0F, 4, "nor");
    do_op(0, CmdOr,   32'hA5A5_A5A5, 32'h0F0F_0F0F, 4, "or");
    do_op(0, CmdXor,  32'h1234_5678, 32'h1234_5678, 4, "xor_zero");

    // Backpressure: hold DONE for 5 cycles with a stray in_valid pulse.
    issue_and_wait(0, CmdAdd, 32'h7FFF_FFFF, 32'h0000_0001, 4, "bp", held);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) set_in(0, 1'b1, CmdSub, 32'h0000_0009, 32'h0000_0003);
      @(posedge clk);
      #1;
      set_in(0, 1'b0, 3'd0, 32'd0, 32'd0);
      now = get_out(0);
      check($sformatf("bp_hold%0d_ov_ir", k), 64'({get_ovalid(0), get_iready(0)}), 64'(2'b10));
      check($sformatf("bp_hold%0d_outs", k), 64'(now), 64'(held));
    end
    retire(0, "bp");
    repeat (6) @(posedge clk);
    #1;
    check("bp_pulse_not_taken", 64'(get_ovalid(0)), 64'd0);

    // Asynchronous reset on the second RUN cycle discards the op.
    @(negedge clk);
    set_in(0, 1'b1, CmdAdd, 32'h0000_0005, 32'h0000_0006);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 3'd0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ov_ir", 64'({get_ovalid(0), get_iready(0)}), 64'(2'b01));
    check("rst_mid_outs", 64'(get_out(0)), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_output", 64'(get_ovalid(0)), 64'd0);
    do_op(0, CmdAdd, 32'h0000_0003, 32'h0000_0004, 4, "post_rst_add");

    // Single-cycle and bit-serial configurations.
    arith_suite(1, 1);
    arith_suite(2, 32);
    do_op(2, CmdSub, 32'h0000_0005, 32'h0000_0005, 32, "i2_sub_eq");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
